dvg_sequencer: RTL and testbench

Instruction sequencer for the digital vector generator. It walks the vector display list in the shared vector memory (vector RAM plus vector ROM, 13-bit byte address space), decodes each instruction and handles jumps, subroutine call and return, and halt. Drawable commands go to the downstream beam generator over a valid/ready handshake. The CPU starts it with the GODVG strobe and polls its halt status.

---
 rtl/dvg_pkg.sv | 38 +++
 rtl/dvg_ret_stack.sv | 60 ++++++
 rtl/dvg_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_dvg_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvg_pkg.sv
// Shared definitions for the vector generator instruction sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dvg_pkg;

    // Instruction opcodes, taken from word[15:12]
    localparam logic [3:0] OP_VCTR_MAX = 4'h9;
    localparam logic [3:0] OP_LABS     = 4'hA;
    localparam logic [3:0] OP_HALT     = 4'hB;
    localparam logic [3:0] OP_JSRL     = 4'hC;
    localparam logic [3:0] OP_RTSL     = 4'hD;
    localparam logic [3:0] OP_JMPL     = 4'hE;
    localparam logic [3:0] OP_SVEC     = 4'hF;

    // Command kinds presented to the beam generator
    localparam logic [1:0] CMD_VCTR = 2'd0;
    localparam logic [1:0] CMD_LABS = 2'd1;
    localparam logic [1:0] CMD_SVEC = 2'd2;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_LO   = 3'd1,
        FETCH_HI   = 3'd2,
        FETCH_WAIT = 3'd3,
        DECODE     = 3'd4,
        EMIT       = 3'd5
    } state_t;

    // Drawable command as handed to the beam generator
    typedef struct packed {
        logic [1:0]  op;
        logic [3:0]  scale;
        logic [3:0]  intens;
        logic [10:0] x;
        logic [10:0] y;
    } cmd_t;

endpackage

// File: rtl/dvg_ret_stack.sv
// Circular return-address stack for JSRL/RTSL; push on full overwrites the oldest entry.
// Latency: push/pop take effect at the next clk edge; dout/empty/full/err are combinational.
// Backpressure: none; err pulses on push-when-full or pop-when-empty (pop on empty is ignored).
//
// Ports: clk, reset (async active-low), push/pop/clear controls, din return word address,
//        dout top-of-stack, empty/full status, err single-cycle error pulse.
module dvg_ret_stack #(
    parameter int AW        = 13,
    parameter int STK_DEPTH = 4     // power of two, at least 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [AW-2:0] din,
    output logic [AW-2:0] dout,
    output logic          empty,
    output logic          full,
    output logic          err
);

    localparam int         PW       = $clog2(STK_DEPTH);
    localparam logic [PW:0] FULL_CNT = STK_DEPTH[PW:0];

    logic [AW-2:0] stk_mem [STK_DEPTH];
    logic [PW-1:0] wp;      // next free slot; wraps so a full push lands on the oldest entry
    logic [PW:0]   cnt;     // live entries, saturates at STK_DEPTH

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign dout  = stk_mem[wp - 1'b1];
    assign err   = (push && full) || (pop && empty);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            cnt <= '0;
        end else if (clear) begin
            wp  <= '0;
            cnt <= '0;
        end else if (push) begin
            wp <= wp + 1'b1;
            if (!full) begin
                cnt <= cnt + 1'b1;
            end
        end else if (pop && !empty) begin
            wp  <= wp - 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

    // Entry storage needs no reset: an entry is only read after it was pushed.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            stk_mem[wp] <= din;
        end
    end

endmodule

// File: rtl/dvg_sequencer.sv
// Vector display-list sequencer: fetches 16-bit instructions, handles flow control, emits draw commands.
// Latency: 3-cycle word fetch then DECODE; go -> first mem_a next cycle; HALT decode -> halted next cycle.
// Backpressure: EMIT holds cmd_valid and all cmd_* fields until cmd_ready; go aborts without transfer.
//
// Ports: clk, reset (async active-low), go start strobe, halted status, mem_a/mem_d byte-wide
//        vector memory (read data one cycle after address), cmd_valid/cmd_ready + cmd_op/scale/int/x/y
//        command channel, stk_err sticky return-stack error.
module dvg_sequencer
    import dvg_pkg::*;
#(
    parameter int AW         = 13,
    parameter int STK_DEPTH  = 4,
    parameter int START_WORD = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    output logic          halted,
    output logic [AW-1:0] mem_a,
    input  logic [7:0]    mem_d,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [1:0]    cmd_op,
    output logic [3:0]    cmd_scale,
    output logic [3:0]    cmd_int,
    output logic [10:0]   cmd_x,
    output logic [10:0]   cmd_y,
    output logic          stk_err
);

    localparam logic [AW-2:0] START_PC = START_WORD[AW-2:0];

    state_t        state, state_nxt;
    logic [AW-2:0] pc, pc_nxt;
    logic [AW-2:0] pc_p1, pc_p2;
    logic          second, second_nxt;      // 1 while fetching/decoding the second word
    logic [AW-1:0] mem_a_q, mem_a_nxt;
    logic [7:0]    lo_byte;
    logic [15:0]   w0;
    logic [14:0]   w1;                      // second word minus bit 11, which no command uses
    logic [3:0]    op;
    cmd_t          cmd_q, cmd_nxt;
    logic          stk_err_q;

    logic          stk_push, stk_pop, stk_clear;
    logic [AW-2:0] stk_dout;
    logic          stk_empty, stk_full, stk_errp;

    assign op    = w0[15:12];
    assign pc_p1 = pc + 1'b1;               // PC arithmetic wraps at 2^(AW-1)
    assign pc_p2 = pc + 2'd2;

    dvg_ret_stack #(
        .AW        (AW),
        .STK_DEPTH (STK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .clear (stk_clear),
        .din   (pc_p1),
        .dout  (stk_dout),
        .empty (stk_empty),
        .full  (stk_full),
        .err   (stk_errp)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        second_nxt = second;
        mem_a_nxt  = mem_a_q;
        cmd_nxt    = cmd_q;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_clear  = 1'b0;
        if (go) begin
            // go wins over everything, including a pending handshake or HALT decode
            state_nxt  = FETCH_LO;
            pc_nxt     = START_PC;
            second_nxt = 1'b0;
            stk_clear  = 1'b1;
            mem_a_nxt  = {START_PC, 1'b0};
        end else begin
            case (state)
                FETCH_LO: begin
                    state_nxt = FETCH_HI;
                    mem_a_nxt = {mem_a_q[AW-1:1], 1'b1};
                end
                FETCH_HI:   state_nxt = FETCH_WAIT;
                FETCH_WAIT: state_nxt = DECODE;
                DECODE: begin
                    if (second) begin
                        second_nxt = 1'b0;
                        pc_nxt     = pc_p2;
                        state_nxt  = EMIT;
                        cmd_nxt.x  = w1[10:0];
                        cmd_nxt.y  = w0[10:0];
                        if (op == OP_LABS) begin
                            cmd_nxt.op     = CMD_LABS;
                            cmd_nxt.scale  = w1[14:11];
                            cmd_nxt.intens = 4'd0;
                        end else begin
                            cmd_nxt.op     = CMD_VCTR;
                            cmd_nxt.scale  = op;
                            cmd_nxt.intens = w1[14:11];
                        end
                    end else if (op <= OP_VCTR_MAX || op == OP_LABS) begin
                        second_nxt = 1'b1;
                        state_nxt  = FETCH_LO;
                        mem_a_nxt  = {pc_p1, 1'b0};
                    end else begin
                        case (op)
                            OP_HALT: state_nxt = IDLE;
                            OP_JSRL: begin
                                stk_push  = 1'b1;
                                pc_nxt    = w0[AW-2:0];
                                state_nxt = FETCH_LO;
                                mem_a_nxt = {w0[AW-2:0], 1'b0};
                            end
                            OP_RTSL: begin
                                stk_pop = 1'b1;
                                if (stk_empty) begin
                                    state_nxt = IDLE;   // underflow behaves as HALT
                                end else begin
                                    pc_nxt    = stk_dout;
                                    state_nxt = FETCH_LO;
                                    mem_a_nxt = {stk_dout, 1'b0};
                                end
                            end
                            OP_JMPL: begin
                                pc_nxt    = w0[AW-2:0];
                                state_nxt = FETCH_LO;
                                mem_a_nxt = {w0[AW-2:0], 1'b0};
                            end
                            default: begin      // OP_SVEC
                                pc_nxt         = pc_p1;
                                state_nxt      = EMIT;
                                cmd_nxt.op     = CMD_SVEC;
                                cmd_nxt.scale  = {2'b00, w0[11], w0[3]};
                                cmd_nxt.intens = w0[7:4];
                                cmd_nxt.x      = {w0[2], 5'b0, w0[1:0], 3'b0};
                                cmd_nxt.y      = {w0[10], 5'b0, w0[9:8], 3'b0};
                            end
                        endcase
                    end
                end
                EMIT: begin
                    // PC already points past the command; refetch from there after the transfer
                    if (cmd_ready) begin
                        state_nxt = FETCH_LO;
                        mem_a_nxt = {pc, 1'b0};
                    end
                end
                default: ;  // IDLE waits for go
            endcase
        end
    end

    // Outputs
    always_comb begin
        halted    = (state == IDLE);
        cmd_valid = (state == EMIT);
        mem_a     = mem_a_q;
        cmd_op    = cmd_q.op;
        cmd_scale = cmd_q.scale;
        cmd_int   = cmd_q.intens;
        cmd_x     = cmd_q.x;
        cmd_y     = cmd_q.y;
        stk_err   = stk_err_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= '0;
            second    <= 1'b0;
            mem_a_q   <= '0;
            cmd_q     <= '0;
            stk_err_q <= 1'b0;
            lo_byte   <= '0;
            w0        <= '0;
            w1        <= '0;
        end else begin
            pc      <= pc_nxt;
            second  <= second_nxt;
            mem_a_q <= mem_a_nxt;
            cmd_q   <= cmd_nxt;
            if (go) begin
                stk_err_q <= 1'b0;
            end else if (stk_errp) begin
                stk_err_q <= 1'b1;
            end
            if (state == FETCH_HI) begin
                lo_byte <= mem_d;
            end
            if (state == FETCH_WAIT) begin
                if (second) begin
                    w1 <= {mem_d[7:4], mem_d[2:0], lo_byte};
                end else begin
                    w0 <= {mem_d, lo_byte};
                end
            end
        end
    end

    // A push onto a full stack must always be flagged
    a_push_full_err: assert property (@(posedge clk) disable iff (!reset)
        (stk_push && stk_full) |-> stk_errp);

endmodule

// File: tb/tb_dvg_sequencer.sv
// Directed bench for dvg_sequencer with a byte-wide memory model and a negedge monitor.
// Latency: n/a.
// Backpressure: cmd_ready driven per test.
module tb_dvg_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic        halted;
    logic [12:0] mem_a;
    logic [7:0]  mem_d = 8'h00;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_scale;
    logic [3:0]  cmd_int;
    logic [10:0] cmd_x;
    logic [10:0] cmd_y;
    logic        stk_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dvg_sequencer #(.AW(13), .STK_DEPTH(4), .START_WORD(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .halted    (halted),
        .mem_a     (mem_a),
        .mem_d     (mem_d),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_scale (cmd_scale),
        .cmd_int   (cmd_int),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .stk_err   (stk_err)
    );

    // Vector memory: read data valid one cycle after the address
    logic [7:0] vmem [0:8191];
    always @(posedge clk) mem_d <= vmem[mem_a];

    // Monitor: fetch-address trace, transfers, field stability under stall
    logic [12:0] trace[$];
    logic [13:0] prev_a = 14'h3FFF;
    int          xfers = 0;
    int          stab_err = 0;
    int          vld_idle = 0;
    logic        pv = 1'b0, pr = 1'b0;
    logic [31:0] pf = '0;
    logic [31:0] last_cmd = '0;

    always @(negedge clk) begin
        if (go) begin
            trace.delete();
            prev_a = 14'h3FFF;
            xfers  = 0;
        end else begin
            if ({1'b0, mem_a} != prev_a) begin
                prev_a = {1'b0, mem_a};
                if (!mem_a[0]) trace.push_back(mem_a);
            end
            if (cmd_valid && cmd_ready) begin
                xfers++;
                last_cmd = {cmd_op, cmd_scale, cmd_int, cmd_x, cmd_y};
            end
            if (cmd_valid && halted) vld_idle++;
            if (cmd_valid && pv && !pr && ({cmd_op, cmd_scale, cmd_int, cmd_x, cmd_y} != pf)) stab_err++;
        end
        pv = cmd_valid;
        pr = cmd_ready;
        pf = {cmd_op, cmd_scale, cmd_int, cmd_x, cmd_y};
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input int w, input logic [15:0] d);
        vmem[2*w]   = d[7:0];
        vmem[2*w+1] = d[15:8];
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 4096; i++) put_word(i, 16'hB000);
    endtask

    task automatic run_go();
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 500) begin step(); n++; end
        chk_val(tag, {31'b0, halted}, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!cmd_valid && n < 500) begin step(); n++; end
        chk_val(tag, {31'b0, cmd_valid}, 32'd1);
    endtask

    task automatic wait_addr(input string tag, input logic [12:0] a);
        int n = 0;
        while (mem_a != a && n < 500) begin step(); n++; end
        chk_val(tag, {19'b0, mem_a}, {19'b0, a});
    endtask

    function automatic logic [31:0] tr_at(input int i);
        if (i < trace.size()) return {19'b0, trace[i]};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] cur_cmd();
        return {cmd_op, cmd_scale, cmd_int, cmd_x, cmd_y};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        fill_halt();

        // Reset values
        repeat (3) step();
        chk_val("rst_halted", {31'b0, halted}, 32'd1);
        chk_val("rst_valid", {31'b0, cmd_valid}, 32'd0);
        chk_val("rst_mem_a", {19'b0, mem_a}, 32'd0);
        chk_val("rst_cmd", cur_cmd(), 32'd0);
        chk_val("rst_stk_err", {31'b0, stk_err}, 32'd0);
        reset = 1'b1;
        step();

        // HALT at word 0: go latency
        run_go();
        chk_val("lat_mem_a_c1", {19'b0, mem_a}, 32'd0);
        chk_val("lat_halt_c1", {31'b0, halted}, 32'd0);
        step(); step(); step();
        chk_val("lat_halt_c4", {31'b0, halted}, 32'd0);
        step();
        chk_val("lat_halt_c5", {31'b0, halted}, 32'd1);
        chk_val("lat_xfers", xfers, 32'd0);

        // VCTR with 10 stalled cycles
        put_word(0, 16'h7405);
        put_word(1, 16'h5123);
        put_word(2, 16'hB000);
        cmd_ready = 1'b0;
        run_go();
        wait_valid("vctr_wait");
        nv = 0;
        repeat (10) begin
            if (cmd_valid) nv++;
            step();
        end
        chk_val("vctr_stall_cycles", nv, 32'd10);
        chk_val("vctr_fields", cur_cmd(), {2'd0, 4'd7, 4'd5, 11'h123, 11'h405});
        cmd_ready = 1'b1;
        wait_halt("vctr_halt");
        chk_val("vctr_xfers", xfers, 32'd1);
        chk_val("vctr_last", last_cmd, {2'd0, 4'd7, 4'd5, 11'h123, 11'h405});
        chk_val("vctr_stable", stab_err, 32'd0);

        // LABS
        fill_halt();
        put_word(0, 16'hA123);
        put_word(1, 16'h9456);
        run_go();
        wait_halt("labs_halt");
        chk_val("labs_xfers", xfers, 32'd1);
        chk_val("labs_last", last_cmd, {2'd1, 4'd9, 4'd0, 11'h456, 11'h123});

        // JSRL / SVEC / RTSL
        fill_halt();
        put_word(0, 16'hC010);
        put_word(16'h010, 16'hF573);
        put_word(16'h011, 16'hD000);
        run_go();
        wait_halt("jsr_halt");
        chk_val("jsr_trace_n", trace.size(), 32'd4);
        chk_val("jsr_tr0", tr_at(0), 32'h0000);
        chk_val("jsr_tr1", tr_at(1), 32'h0020);
        chk_val("jsr_tr2", tr_at(2), 32'h0022);
        chk_val("jsr_tr3", tr_at(3), 32'h0002);
        chk_val("jsr_xfers", xfers, 32'd1);
        chk_val("jsr_svec", last_cmd, {2'd2, 4'd0, 4'd7, 11'h018, 11'h408});
        chk_val("jsr_stk_err", {31'b0, stk_err}, 32'd0);

        // Five nested calls into a four-entry stack
        fill_halt();
        put_word(0, 16'hC010);
        put_word(1, 16'hF573);     // would transfer if the lost entry were returned to
        put_word(16'h010, 16'hC020);
        put_word(16'h020, 16'hC030);
        put_word(16'h030, 16'hC040);
        put_word(16'h040, 16'hC050);
        put_word(16'h050, 16'hD000);
        put_word(16'h041, 16'hD000);
        put_word(16'h031, 16'hD000);
        put_word(16'h021, 16'hD000);
        put_word(16'h011, 16'hD000);
        run_go();
        wait_addr("stk_a80", 13'h080);
        chk_val("stk_err_4push", {31'b0, stk_err}, 32'd0);
        wait_addr("stk_aA0", 13'h0A0);
        chk_val("stk_err_5push", {31'b0, stk_err}, 32'd1);
        wait_halt("stk_halt");
        chk_val("stk_err_end", {31'b0, stk_err}, 32'd1);
        chk_val("stk_xfers", xfers, 32'd0);
        chk_val("stk_trace_n", trace.size(), 32'd10);
        chk_val("stk_tr6", tr_at(6), 32'h0082);
        chk_val("stk_tr9", tr_at(9), 32'h0022);
        run_go();
        chk_val("stk_err_clr", {31'b0, stk_err}, 32'd0);
        wait_halt("stk_halt2");

        // go during EMIT, same cycle as cmd_ready
        fill_halt();
        put_word(0, 16'hF573);
        cmd_ready = 1'b0;
        run_go();
        wait_valid("abort_wait");
        chk_val("abort_pre_a", {19'b0, mem_a}, 32'h0001);
        cmd_ready = 1'b1;
        run_go();
        chk_val("abort_valid", {31'b0, cmd_valid}, 32'd0);
        chk_val("abort_mem_a", {19'b0, mem_a}, 32'h0000);
        wait_halt("abort_halt");
        chk_val("abort_xfers", xfers, 32'd1);

        // JMPL to the top word and wrap back to 0
        fill_halt();
        put_word(0, 16'hEFFF);
        put_word(12'hFFF, 16'hFA5C);
        cmd_ready = 1'b0;
        run_go();
        wait_valid("wrap_wait");
        chk_val("wrap_hold_a", {19'b0, mem_a}, 32'h1FFF);
        chk_val("wrap_fields", cur_cmd(), {2'd2, 4'd3, 4'd5, 11'h400, 11'h010});
        put_word(0, 16'hB000);
        cmd_ready = 1'b1;
        wait_halt("wrap_halt");
        chk_val("wrap_xfers", xfers, 32'd1);
        chk_val("wrap_trace_n", trace.size(), 32'd3);
        chk_val("wrap_tr1", tr_at(1), 32'h1FFE);
        chk_val("wrap_tr2", tr_at(2), 32'h0000);

        chk_val("valid_while_idle", vld_idle, 32'd0);
        chk_val("stable_all", stab_err, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
